// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
//
// Hazard and stall controller for the 5-stage pipelined MIPS core. It sits
// beside the ID stage and replaces the old purely combinational load-use
// detector. It handles three kinds of event:
//   - load-use hazards: inserts LOAD_USE_STALLS bubbles into ID/EX while PC
//     and IF/ID hold;
//   - taken branches/jumps resolved in EX: flush IF/ID for FLUSH_SLOTS cycles;
//   - data-memory busy: freeze the whole pipe. Stall and flush progress is
//     paused, so a busy period stretches a stall instead of consuming it.
//
// Parameters
//   REG_ADDR_W      width of register specifiers
//   LOAD_USE_STALLS bubbles per load-use hazard (1..7)
//   FLUSH_SLOTS     cycles if_id_flush stays high after a taken branch (1..3)
//   ZERO_REG_EXCL   1: a load targeting register 0 never causes a stall
//
// Ports
//   clk, rst_n      clock (rising edge), synchronous active-low reset
//   id_ex_rt        destination register of the instruction in EX
//   id_ex_memread   instruction in EX is a load
//   if_id_rs/rt     source registers of the instruction in ID
//   if_id_uses_rs/rt  instruction in ID really reads rs / rt
//   branch_taken    branch/jump resolved taken in EX
//   dmem_busy       data memory not ready; whole pipe must hold
//   pcwrite         PC update enable
//   if_id_write     IF/ID register enable
//   hu_sel          1 = ID/EX control fields zeroed (bubble)
//   if_id_flush     clear IF/ID to NOP
//   pipe_hold       freeze ID/EX, EX/MEM and MEM/WB
//   stall_cycles    (HAZARD_CTRL_PERF_EN only) bubble cycles, saturating
//   flush_cycles    (HAZARD_CTRL_PERF_EN only) flush cycles, saturating
//
// Optional feature macro: HAZARD_CTRL_PERF_EN adds the two performance
// counters. Without it the ports and counters do not exist.
// -----------------------------------------------------------------------------
module hazard_ctrl_unit #(
    parameter int REG_ADDR_W      = 5,
    parameter int LOAD_USE_STALLS = 1,
    parameter int FLUSH_SLOTS     = 1,
    parameter int ZERO_REG_EXCL   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_ex_rt,
    input  logic                  id_ex_memread,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    input  logic                  if_id_uses_rs,
    input  logic                  if_id_uses_rt,
    input  logic                  branch_taken,
    input  logic                  dmem_busy,
`ifdef HAZARD_CTRL_PERF_EN
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_cycles,
`endif
    output logic                  pcwrite,
    output logic                  if_id_write,
    output logic                  hu_sel,
    output logic                  if_id_flush,
    output logic                  pipe_hold
);

    // -------------------------------------------------------------------------
    // Parameter range checks: out-of-range values stop elaboration.
    // -------------------------------------------------------------------------
    generate
        if (REG_ADDR_W < 1) begin : g_bad_addr_w
            $error("hazard_ctrl_unit: REG_ADDR_W must be at least 1");
        end
        if (LOAD_USE_STALLS < 1 || LOAD_USE_STALLS > 7) begin : g_bad_lus
            $error("hazard_ctrl_unit: LOAD_USE_STALLS must be in 1..7");
        end
        if (FLUSH_SLOTS < 1 || FLUSH_SLOTS > 3) begin : g_bad_fs
            $error("hazard_ctrl_unit: FLUSH_SLOTS must be in 1..3");
        end
        if (ZERO_REG_EXCL < 0 || ZERO_REG_EXCL > 1) begin : g_bad_zx
            $error("hazard_ctrl_unit: ZERO_REG_EXCL must be 0 or 1");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;

    // Counter reload values. The cycle that detects the event is the first
    // stall/flush cycle, so the counter holds the number still to come.
    localparam logic [2:0] LU_RELOAD    = 3'(LOAD_USE_STALLS - 1);
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_SLOTS - 1);
    localparam bit         LU_MULTI     = (LOAD_USE_STALLS > 1);
    localparam bit         FLUSH_MULTI  = (FLUSH_SLOTS > 1);
    localparam bit         EXCL_R0      = (ZERO_REG_EXCL != 0);

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q,   cnt_d;

    // -------------------------------------------------------------------------
    // Load-use detect. Operand usage qualifies each compare so that
    // instructions without an rs/rt read do not stall falsely.
    // -------------------------------------------------------------------------
    logic rt_is_zero;
    logic rs_match;
    logic rt_match;
    logic lu_hit;

    always_comb begin
        rt_is_zero = (id_ex_rt == '0);
        rs_match   = if_id_uses_rs && (id_ex_rt == if_id_rs);
        rt_match   = if_id_uses_rt && (id_ex_rt == if_id_rt);
        lu_hit     = id_ex_memread && !(EXCL_R0 && rt_is_zero)
                     && (rs_match || rt_match);
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic.
    // Priority: reset, dmem_busy, branch_taken, then load-use handling.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pcwrite     = 1'b1;
        if_id_write = 1'b1;
        hu_sel      = 1'b0;
        if_id_flush = 1'b0;
        pipe_hold   = 1'b0;

        if (!rst_n) begin
            // Front end held and squashed while in reset; back end runs.
            pcwrite     = 1'b0;
            if_id_write = 1'b0;
            hu_sel      = 1'b1;
            if_id_flush = 1'b1;
            state_d     = ST_RUN;
            cnt_d       = 3'd0;
        end else if (dmem_busy) begin
            // Full freeze. State and counter hold so the stall or flush
            // resumes exactly where it left off once memory is ready.
            pcwrite     = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
        end else if (branch_taken) begin
            // A taken branch wins in every state: squash the wrong-path
            // instruction in ID. Any coincident load-use hit belongs to that
            // squashed instruction and is dropped, and an ongoing stall is
            // abandoned. In FLUSH this reloads the flush window.
            if_id_flush = 1'b1;
            hu_sel      = 1'b1;
            if (FLUSH_MULTI) begin
                state_d = ST_FLUSH;
                cnt_d   = FLUSH_RELOAD;
            end else begin
                state_d = ST_RUN;
                cnt_d   = 3'd0;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (lu_hit) begin
                        pcwrite     = 1'b0;
                        if_id_write = 1'b0;
                        hu_sel      = 1'b1;
                        if (LU_MULTI) begin
                            state_d = ST_LU_STALL;
                            cnt_d   = LU_RELOAD;
                        end
                    end
                end

                ST_LU_STALL: begin
                    // EX holds a bubble now, so lu_hit is not re-evaluated.
                    pcwrite     = 1'b0;
                    if_id_write = 1'b0;
                    hu_sel      = 1'b1;
                    if (cnt_q <= 3'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end

                ST_FLUSH: begin
                    if_id_flush = 1'b1;
                    hu_sel      = 1'b1;
                    if (cnt_q <= 3'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to RUN.
                    state_d = ST_RUN;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    // -------------------------------------------------------------------------
    // Performance counters. A bubble cycle is one where ID/EX is zeroed but
    // not because of a flush; freeze cycles have hu_sel=0 and if_id_flush=0,
    // so both counters naturally hold while dmem_busy is high.
    // -------------------------------------------------------------------------
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hu_sel && !if_id_flush && !pipe_hold && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (if_id_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// Bench for hazard_ctrl_unit. Three instances share one stimulus stream:
//   inst0: defaults (LOAD_USE_STALLS=1, FLUSH_SLOTS=1, ZERO_REG_EXCL=1)
//   inst1: LOAD_USE_STALLS=3, FLUSH_SLOTS=2, ZERO_REG_EXCL=1
//   inst2: LOAD_USE_STALLS=1, FLUSH_SLOTS=1, ZERO_REG_EXCL=0
// Inputs change #1 after the rising edge; outputs are checked on the falling
// edge, both against a cycle model and against hand-computed literals.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] id_ex_rt, if_id_rs, if_id_rt;
  logic       id_ex_memread, uses_rs, uses_rt, branch_taken, dmem_busy;

  logic [2:0] pcw, ifw, hus, fls, hld;
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] sc [3];
  logic [31:0] fc [3];
`endif

  int vectors = 0;
  int miscompares = 0;

  hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(1), .FLUSH_SLOTS(1), .ZERO_REG_EXCL(1)) u_def (
    .clk(clk), .rst_n(rst_n), .id_ex_rt(id_ex_rt), .id_ex_memread(id_ex_memread),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rs(uses_rs), .if_id_uses_rt(uses_rt),
    .branch_taken(branch_taken), .dmem_busy(dmem_busy),
`ifdef HAZARD_CTRL_PERF_EN
    .stall_cycles(sc[0]), .flush_cycles(fc[0]),
`endif
    .pcwrite(pcw[0]), .if_id_write(ifw[0]), .hu_sel(hus[0]), .if_id_flush(fls[0]), .pipe_hold(hld[0])
  );

  hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(3), .FLUSH_SLOTS(2), .ZERO_REG_EXCL(1)) u_lu3 (
    .clk(clk), .rst_n(rst_n), .id_ex_rt(id_ex_rt), .id_ex_memread(id_ex_memread),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rs(uses_rs), .if_id_uses_rt(uses_rt),
    .branch_taken(branch_taken), .dmem_busy(dmem_busy),
`ifdef HAZARD_CTRL_PERF_EN
    .stall_cycles(sc[1]), .flush_cycles(fc[1]),
`endif
    .pcwrite(pcw[1]), .if_id_write(ifw[1]), .hu_sel(hus[1]), .if_id_flush(fls[1]), .pipe_hold(hld[1])
  );

  hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(1), .FLUSH_SLOTS(1), .ZERO_REG_EXCL(0)) u_nz (
    .clk(clk), .rst_n(rst_n), .id_ex_rt(id_ex_rt), .id_ex_memread(id_ex_memread),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rs(uses_rs), .if_id_uses_rt(uses_rt),
    .branch_taken(branch_taken), .dmem_busy(dmem_busy),
`ifdef HAZARD_CTRL_PERF_EN
    .stall_cycles(sc[2]), .flush_cycles(fc[2]),
`endif
    .pcwrite(pcw[2]), .if_id_write(ifw[2]), .hu_sel(hus[2]), .if_id_flush(fls[2]), .pipe_hold(hld[2])
  );

  // ---------------- behavioural model + compare ----------------
  // The model tracks only "bubbles still owed" and "flush cycles still owed"
  // per instance and derives the output vector {pcwrite, if_id_write, hu_sel,
  // if_id_flush, pipe_hold} from the priority rules.
  int lus_p [3] = '{1, 3, 1};
  int fs_p  [3] = '{1, 2, 1};
  int zx_p  [3] = '{1, 1, 0};
  int stall_left [3] = '{0, 0, 0};
  int flush_left [3] = '{0, 0, 0};
  int m_sc [3] = '{0, 0, 0};
  int m_fc [3] = '{0, 0, 0};
  int cyc = 0;

  logic [4:0] exp_v, act_v;
  logic       hit_v;

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      hit_v = id_ex_memread && !(zx_p[k] == 1 && id_ex_rt == 5'd0) &&
              ((uses_rs && id_ex_rt == if_id_rs) || (uses_rt && id_ex_rt == if_id_rt));
      if (!rst_n) begin
        exp_v = 5'b00110;
        stall_left[k] = 0;
        flush_left[k] = 0;
      end else if (dmem_busy) begin
        exp_v = 5'b00001;
      end else if (branch_taken) begin
        exp_v = 5'b11110;
        flush_left[k] = fs_p[k] - 1;
        stall_left[k] = 0;
      end else if (flush_left[k] > 0) begin
        exp_v = 5'b11110;
        flush_left[k]--;
      end else if (stall_left[k] > 0) begin
        exp_v = 5'b00100;
        stall_left[k]--;
      end else if (hit_v) begin
        exp_v = 5'b00100;
        stall_left[k] = lus_p[k] - 1;
      end else begin
        exp_v = 5'b11000;
      end
      act_v = {pcw[k], ifw[k], hus[k], fls[k], hld[k]};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL model_cmp inst%0d cycle %0d: got %b required %b (pcw,ifw,hu,fl,hold)",
                 k, cyc, act_v, exp_v);
      end
`ifdef HAZARD_CTRL_PERF_EN
      if (rst_n) begin
        vectors++;
        if (sc[k] !== 32'(m_sc[k])) begin
          miscompares++;
          $display("FAIL model_stall_cycles inst%0d cycle %0d: got %0d required %0d", k, cyc, sc[k], m_sc[k]);
        end
        vectors++;
        if (fc[k] !== 32'(m_fc[k])) begin
          miscompares++;
          $display("FAIL model_flush_cycles inst%0d cycle %0d: got %0d required %0d", k, cyc, fc[k], m_fc[k]);
        end
        if (exp_v[2] && !exp_v[1] && !exp_v[0]) m_sc[k]++;
        if (exp_v[1]) m_fc[k]++;
      end else begin
        m_sc[k] = 0;
        m_fc[k] = 0;
      end
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    id_ex_memread = 1'b0;
    id_ex_rt      = 5'd0;
    if_id_rs      = 5'd0;
    if_id_rt      = 5'd0;
    uses_rs       = 1'b0;
    uses_rt       = 1'b0;
    branch_taken  = 1'b0;
    dmem_busy     = 1'b0;
  endtask

  task automatic load_use_rs8();
    id_ex_memread = 1'b1;
    id_ex_rt      = 5'd8;
    if_id_rs      = 5'd8;
    uses_rs       = 1'b1;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic act, input logic exp_b);
    vectors++;
    if (act !== exp_b) begin
      miscompares++;
      $display("FAIL %s: got %b required %b", nm, act, exp_b);
    end
  endtask

  task automatic lit32(input string nm, input logic [31:0] act, input logic [31:0] exp_w);
    vectors++;
    if (act !== exp_w) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp_w);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    lit("rst_pcwrite", pcw[0], 1'b0);
    lit("rst_ifwrite", ifw[0], 1'b0);
    lit("rst_flush", fls[0], 1'b1);
    lit("rst_husel", hus[1], 1'b1);
    lit("rst_hold", hld[2], 1'b0);

    adv(); rst_n = 1'b1; idle();
    @(negedge clk);
    lit("idle_pcwrite", pcw[0], 1'b1);
    lit("idle_husel", hus[1], 1'b0);

    // load-use on rs, one cycle
    adv(); load_use_rs8();
    @(negedge clk);
    lit("lu1_pcw_def", pcw[0], 1'b0);
    lit("lu1_ifw_def", ifw[0], 1'b0);
    lit("lu1_hu_def", hus[0], 1'b1);
    lit("lu1_pcw_lu3", pcw[1], 1'b0);
    adv(); idle();
    @(negedge clk);
    lit("lu2_pcw_def", pcw[0], 1'b1);
    lit("lu2_hu_def", hus[0], 1'b0);
    lit("lu2_pcw_lu3", pcw[1], 1'b0);
    adv();
    @(negedge clk);
    lit("lu3_pcw_lu3", pcw[1], 1'b0);
    adv();
    @(negedge clk);
    lit("lu4_pcw_lu3", pcw[1], 1'b1);
    lit("lu4_hu_lu3", hus[1], 1'b0);

    // same registers but rs not used, rt differs: no stall
    adv(); load_use_rs8(); uses_rs = 1'b0; if_id_rt = 5'd9; uses_rt = 1'b1;
    @(negedge clk);
    lit("nouse_pcw_def", pcw[0], 1'b1);
    lit("nouse_pcw_lu3", pcw[1], 1'b1);

    // match through rt
    adv(); if_id_rt = 5'd8;
    @(negedge clk);
    lit("rt_hit_pcw_def", pcw[0], 1'b0);
    adv(); idle();
    adv(); adv();

    // load to register 0
    adv(); id_ex_memread = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0; uses_rs = 1'b1;
    @(negedge clk);
    lit("zero_pcw_excl", pcw[0], 1'b1);
    lit("zero_pcw_noexcl", pcw[2], 1'b0);
    adv(); idle();
    @(negedge clk);
    lit("zero_after_noexcl", pcw[2], 1'b1);

    // branch coincident with load-use
    adv(); load_use_rs8(); branch_taken = 1'b1;
    @(negedge clk);
    lit("br_lu_fl_def", fls[0], 1'b1);
    lit("br_lu_hu_def", hus[0], 1'b1);
    lit("br_lu_pcw_def", pcw[0], 1'b1);
    lit("br_lu_fl_lu3", fls[1], 1'b1);
    adv(); idle();
    @(negedge clk);
    lit("br2_fl_def", fls[0], 1'b0);
    lit("br2_fl_fs2", fls[1], 1'b1);
    lit("br2_pcw_fs2", pcw[1], 1'b1);
    adv();
    @(negedge clk);
    lit("br3_fl_fs2", fls[1], 1'b0);
    lit("br3_pcw_fs2", pcw[1], 1'b1);

    // dmem_busy for 4 cycles in place of the second stall cycle
    adv(); load_use_rs8();
    @(negedge clk);
    lit("busyA_pcw", pcw[1], 1'b0);
    adv(); idle(); dmem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      lit("busy_hold", hld[1], 1'b1);
      lit("busy_hu", hus[1], 1'b0);
      lit("busy_pcw", pcw[1], 1'b0);
      adv();
    end
    dmem_busy = 1'b0;
    @(negedge clk);
    lit("post_busy_stall2_hu", hus[1], 1'b1);
    lit("post_busy_stall2_hold", hld[1], 1'b0);
    adv();
    @(negedge clk);
    lit("post_busy_stall3_pcw", pcw[1], 1'b0);
    adv();
    @(negedge clk);
    lit("post_busy_done_pcw", pcw[1], 1'b1);
    lit("post_busy_done_hu", hus[1], 1'b0);

    // branch abandons an ongoing stall
    adv(); load_use_rs8();
    adv(); idle(); branch_taken = 1'b1;
    @(negedge clk);
    lit("abandon_fl", fls[1], 1'b1);
    lit("abandon_pcw", pcw[1], 1'b1);
    adv(); branch_taken = 1'b0;
    @(negedge clk);
    lit("abandon_fl2", fls[1], 1'b1);
    adv();
    @(negedge clk);
    lit("abandon_done_fl", fls[1], 1'b0);
    lit("abandon_done_pcw", pcw[1], 1'b1);

    // second branch during FLUSH reloads the window
    adv(); branch_taken = 1'b1;
    adv();
    @(negedge clk);
    lit("reload_fl1", fls[1], 1'b1);
    adv(); branch_taken = 1'b0;
    @(negedge clk);
    lit("reload_fl2", fls[1], 1'b1);
    adv();
    @(negedge clk);
    lit("reload_done", fls[1], 1'b0);

    // reset in the middle of a stall
    adv(); load_use_rs8();
    adv(); idle(); rst_n = 1'b0;
    @(negedge clk);
    lit("midrst_fl", fls[1], 1'b1);
    adv(); rst_n = 1'b1;
    @(negedge clk);
    lit("postrst_pcw", pcw[1], 1'b1);
    lit("postrst_hu", hus[1], 1'b0);

    // one load-use hazard then one taken branch after reset
    adv(); load_use_rs8();
    adv(); idle();
    adv();
    adv(); branch_taken = 1'b1;
    adv(); branch_taken = 1'b0;
    adv();
    @(negedge clk);
    lit("perf_seq_done_pcw", pcw[1], 1'b1);
`ifdef HAZARD_CTRL_PERF_EN
    lit32("perf_stall_lu3", sc[1], 32'd3);
    lit32("perf_flush_fs2", fc[1], 32'd2);
    lit32("perf_stall_def", sc[0], 32'd1);
    lit32("perf_flush_def", fc[0], 32'd1);
`endif

    adv();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
